// File: rtl/med_pkg.sv
// rtl/med_pkg.sv - shared line-buffer defaults and FSM state type
package med_pkg;

    localparam int DEF_ROW   = 512;
    localparam int DEF_COL   = 512;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2,
        FLUSH  = 2'd3
    } lb_state_t;

endpackage

// File: rtl/line_buf_3x512_if.sv
// rtl/line_buf_3x512_if.sv - pixel-in / line-triple-out handshake bundle
interface line_buf_3x512_if
    import med_pkg::*;
#(
    parameter int ROW   = DEF_ROW,
    parameter int width = DEF_WIDTH
);

    logic [width-1:0]     pix_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [0:ROW*width-1] line1;
    logic [0:ROW*width-1] line2;
    logic [0:ROW*width-1] line3;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport slave (
        input  pix_in, in_valid, out_ready,
        output in_ready, line1, line2, line3, out_valid, out_last
    );

    modport master (
        output pix_in, in_valid, out_ready,
        input  in_ready, line1, line2, line3, out_valid, out_last
    );

endinterface

// File: rtl/line_buf_3x512_line_assembler.sv
// rtl/line_buf_3x512_line_assembler.sv - collects one row of pixels and flags row completion
module line_assembler
    import med_pkg::*;
#(
    parameter int ROW   = DEF_ROW,
    parameter int width = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic [width-1:0]     pix,
    output logic                 row_done,
    output logic [0:ROW*width-1] row_data
);

    localparam int            CW       = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(ROW - 1);

    logic [CW-1:0]        col;
    logic [0:ROW*width-1] asm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col   <= '0;
            asm_q <= '0;
        end else if (accept) begin
            asm_q[width*int'(col) +: width] <= pix;
            col <= (col == LAST_COL) ? '0 : col + CW'(1);
        end
    end

    // The final pixel is merged combinationally so the full row is ready on the completing accept.
    always_comb begin
        row_data = asm_q;
        row_data[width*(ROW-1) +: width] = pix;
    end

    assign row_done = accept && (col == LAST_COL);

endmodule

// File: rtl/line_buf_3x512.sv
// rtl/line_buf_3x512.sv - three-line raster buffer; LINEBUF_BORDER_REPLICATE_EN enables border replication
module line_buf_3x512
    import med_pkg::*;
#(
    parameter int ROW   = DEF_ROW,
    parameter int COL   = DEF_COL,
    parameter int width = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    line_buf_3x512_if.slave         bus
);

    localparam int            RW       = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(COL - 1);

    lb_state_t            state;
    lb_state_t            state_nxt;
    logic [RW-1:0]        row;
    logic [0:ROW*width-1] line1_q;
    logic [0:ROW*width-1] line2_q;
    logic [0:ROW*width-1] line3_q;
    logic                 last_q;
    logic                 accept;
    logic                 row_done;
    logic [0:ROW*width-1] row_data;

    assign bus.in_ready  = (state == FILL) || (state == STREAM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_last  = last_q;
    assign bus.line1     = line1_q;
    assign bus.line2     = line2_q;
    assign bus.line3     = line3_q;

    assign accept = bus.in_valid && bus.in_ready;

    line_assembler #(
        .ROW   (ROW),
        .width (width)
    ) u_assembler (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .pix      (bus.pix_in),
        .row_done (row_done),
        .row_data (row_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (row_done && (row != '0)) begin
`ifdef LINEBUF_BORDER_REPLICATE_EN
                    state_nxt = HOLD;
`else
                    state_nxt = STREAM;
`endif
                end
            end
            STREAM: begin
                if (row_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // row has already wrapped to 0 once the frame's final row is pending
                if (bus.out_ready) begin
                    if (row != '0) begin
                        state_nxt = STREAM;
                    end
`ifdef LINEBUF_BORDER_REPLICATE_EN
                    else if (!last_q) begin
                        state_nxt = FLUSH;
                    end
`endif
                    else begin
                        state_nxt = FILL;
                    end
                end
            end
            FLUSH: begin
                state_nxt = HOLD;
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            row     <= '0;
            line1_q <= '0;
            line2_q <= '0;
            line3_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (row_done) begin
                row     <= (row == LAST_ROW) ? '0 : row + RW'(1);
                line1_q <= line2_q;
                line2_q <= line3_q;
                line3_q <= row_data;
`ifdef LINEBUF_BORDER_REPLICATE_EN
                // seed the top border so row 1 yields (r0, r0, r1)
                if (row == '0) begin
                    line2_q <= row_data;
                end
`else
                last_q <= (row == LAST_ROW);
`endif
            end
`ifdef LINEBUF_BORDER_REPLICATE_EN
            if (state == FLUSH) begin
                line1_q <= line2_q;
                line2_q <= line3_q;
                last_q  <= 1'b1;
            end
`endif
            if ((state == HOLD) && bus.out_ready) begin
                last_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_buf_3x512.sv
// tb/tb_line_buf_3x512.sv - scoreboard bench for line_buf_3x512 at ROW=4, COL=4, width=8
module tb_line_buf_3x512;

    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int W   = 8;
    localparam int LW  = ROW * W;
`ifdef LINEBUF_BORDER_REPLICATE_EN
    localparam int TRIPS = COL;
`else
    localparam int TRIPS = COL - 2;
`endif

    typedef struct {
        logic [0:LW-1] l1;
        logic [0:LW-1] l2;
        logic [0:LW-1] l3;
        logic          last;
    } trip_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    trip_t exp_q[$];
    trip_t got[$];

    always #5 clk = ~clk;

    line_buf_3x512_if #(.ROW(ROW), .width(W)) bus ();

    line_buf_3x512 #(.ROW(ROW), .COL(COL), .width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic trip_t mk(input logic [0:LW-1] a, input logic [0:LW-1] b,
                                 input logic [0:LW-1] c, input logic l);
        trip_t t;
        t.l1 = a; t.l2 = b; t.l3 = c; t.last = l;
        return t;
    endfunction

    task automatic run_traffic(input int nframes, input bit rand_valid, input int stall);
        int total = nframes * ROW * COL;
        int sent = 0;
        int cyc = 0;
        int stall_left = stall;
        int col = 0;
        int row = 0;
        bit lat_pending = 0;
        logic [0:LW-1] cur = '0;
        logic [0:LW-1] rows [COL];
        trip_t t;
        got.delete();
        exp_q.delete();
        while ((sent < total || exp_q.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = (sent < total) && (!rand_valid || $urandom_range(0, 1) == 1);
            bus.pix_in   = bus.in_valid ? W'(sent + 1) : 8'hEE;
            if (bus.out_valid === 1'b1 && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (lat_pending) begin
                checks++;
                if (bus.out_valid !== 1'b1)
                    begin failures++; $display("FAIL latency out_valid=%b expected 1", bus.out_valid); end
                lat_pending = 0;
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.in_ready !== 1'b0)
                    begin failures++; $display("FAIL in_ready_in_hold got=%b expected 0", bus.in_ready); end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_triple got=%h/%h/%h expected none", bus.line1, bus.line2, bus.line3);
                end else begin
                    t = exp_q[0];
                    checks++;
                    if ({bus.line1, bus.line2, bus.line3, bus.out_last} !== {t.l1, t.l2, t.l3, t.last}) begin
                        failures++;
                        $display("FAIL triple got=%h/%h/%h last=%b expected %h/%h/%h last=%b",
                                 bus.line1, bus.line2, bus.line3, bus.out_last, t.l1, t.l2, t.l3, t.last);
                    end
                    if (bus.out_ready) begin
                        got.push_back(mk(bus.line1, bus.line2, bus.line3, bus.out_last));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                cur[W*col +: W] = bus.pix_in;
                sent++;
                if (col == ROW - 1) begin
                    rows[row] = cur;
`ifdef LINEBUF_BORDER_REPLICATE_EN
                    if (row == 1) exp_q.push_back(mk(rows[0], rows[0], rows[1], 1'b0));
                    if (row >= 2) exp_q.push_back(mk(rows[row-2], rows[row-1], rows[row], 1'b0));
                    if (row == COL - 1) exp_q.push_back(mk(rows[row-1], rows[row], rows[row], 1'b1));
                    lat_pending = (row >= 1);
`else
                    if (row >= 2) exp_q.push_back(mk(rows[row-2], rows[row-1], rows[row], row == COL - 1));
                    lat_pending = (row >= 2);
`endif
                    col = 0;
                    row = (row == COL - 1) ? 0 : row + 1;
                end else begin
                    col++;
                end
            end
        end
        checks++;
        if (cyc >= 2000)
            begin failures++; $display("FAIL traffic_timeout sent=%0d pending=%0d expected drained", sent, exp_q.size()); end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL out_valid_deassert got=%b expected 0", bus.out_valid); end
    endtask

    task automatic push_raw(input int n);
        int acc = 0;
        int cyc = 0;
        bus.out_ready = 1'b0;
        while (acc < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'b1;
            bus.pix_in   = W'(8'hA0 + acc);
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (acc != n) begin failures++; $display("FAIL raw_accepts got=%0d expected %0d", acc, n); end
    endtask

    task automatic check_frame1(input string tag);
        checks++;
        if (got.size() != TRIPS) begin
            failures++;
            $display("FAIL %s_count got=%0d expected %0d", tag, got.size(), TRIPS);
        end else begin
            checks++;
`ifdef LINEBUF_BORDER_REPLICATE_EN
            if ({got[0].l1, got[0].l2, got[0].l3, got[0].last} !== {32'h01020304, 32'h01020304, 32'h05060708, 1'b0})
`else
            if ({got[0].l1, got[0].l2, got[0].l3, got[0].last} !== {32'h01020304, 32'h05060708, 32'h090A0B0C, 1'b0})
`endif
                begin failures++; $display("FAIL %s_first got=%h/%h/%h last=%b", tag, got[0].l1, got[0].l2, got[0].l3, got[0].last); end
            checks++;
`ifdef LINEBUF_BORDER_REPLICATE_EN
            if ({got[TRIPS-1].l1, got[TRIPS-1].l2, got[TRIPS-1].l3, got[TRIPS-1].last} !== {32'h090A0B0C, 32'h0D0E0F10, 32'h0D0E0F10, 1'b1})
`else
            if ({got[TRIPS-1].l1, got[TRIPS-1].l2, got[TRIPS-1].l3, got[TRIPS-1].last} !== {32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 1'b1})
`endif
                begin failures++; $display("FAIL %s_last got=%h/%h/%h last=%b", tag, got[TRIPS-1].l1, got[TRIPS-1].l2, got[TRIPS-1].l3, got[TRIPS-1].last); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b001)
            begin failures++; $display("FAIL reset_flags got=%b%b%b expected 001", bus.out_valid, bus.out_last, bus.in_ready); end
        checks++;
        if ({bus.line1, bus.line2, bus.line3} !== '0)
            begin failures++; $display("FAIL reset_lines got=%h/%h/%h expected 0", bus.line1, bus.line2, bus.line3); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        run_traffic(1, 0, 0);
        check_frame1("basic");
    endtask

    task automatic test_stall();
        run_traffic(1, 0, 5);
        check_frame1("stall");
    endtask

    task automatic test_reset_mid();
        push_raw(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_traffic(1, 0, 0);
        check_frame1("rst_mid_row");
`ifdef LINEBUF_BORDER_REPLICATE_EN
        push_raw(2 * ROW);
`else
        push_raw(3 * ROW);
`endif
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_reached got=%b expected 1", bus.out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b001)
            begin failures++; $display("FAIL rst_hold_flags got=%b%b%b expected 001", bus.out_valid, bus.out_last, bus.in_ready); end
        run_traffic(1, 0, 0);
        check_frame1("rst_mid_hold");
    endtask

    task automatic test_back_to_back();
        run_traffic(2, 0, 0);
        checks++;
        if (got.size() != 2 * TRIPS) begin
            failures++;
            $display("FAIL b2b_count got=%0d expected %0d", got.size(), 2 * TRIPS);
        end else begin
            checks++;
            if ({got[0].last, got[TRIPS-1].last, got[TRIPS].last, got[2*TRIPS-1].last} !== 4'b0101)
                begin failures++; $display("FAIL b2b_last got=%b%b%b%b expected 0101", got[0].last, got[TRIPS-1].last, got[TRIPS].last, got[2*TRIPS-1].last); end
            checks++;
            if (got[TRIPS].l1 !== 32'h11121314)
                begin failures++; $display("FAIL b2b_frame2_l1 got=%h expected 11121314", got[TRIPS].l1); end
            checks++;
            if (got[2*TRIPS-1].l3 !== 32'h1D1E1F20)
                begin failures++; $display("FAIL b2b_frame2_l3 got=%h expected 1d1e1f20", got[2*TRIPS-1].l3); end
        end
    endtask

    task automatic test_random_valid();
        run_traffic(1, 1, 0);
        check_frame1("random_valid");
    endtask

    initial begin
        bus.pix_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
